// File: rtl/decoder_8b10b_multilane.sv
// Multi-lane 8b/10b decoder. Each cycle it decodes NUM_SYMBOLS 10-bit symbols
// (symbol 0 earliest). It carries running disparity through the symbols of a
// cycle and across cycles, and it counts erroneous symbols in a saturating
// counter. All outputs are registered, so the latency is one cycle.
module decoder_8b10b_multilane #(
    parameter int   NUM_SYMBOLS   = 2,
    parameter int   ERR_CNT_WIDTH = 16,
    parameter logic RD_INIT       = 1'b0
) (
    input  logic                        BitCLK_10,
    input  logic                        Reset,
    input  logic                        RxValid,
    input  logic [10*NUM_SYMBOLS-1:0]   RxParallel_10,
    input  logic                        ErrCntClear,
    output logic                        RxValidOut,
    output logic [8*NUM_SYMBOLS-1:0]    RxParallel_8,
    output logic [NUM_SYMBOLS-1:0]      RxDataK,
    output logic [NUM_SYMBOLS-1:0]      decode_error,
    output logic [NUM_SYMBOLS-1:0]      disparity_error,
    output logic                        RunningDisparity,
    output logic [ERR_CNT_WIDTH-1:0]    ErrCount
);

    // 6b code in abcdei order (a = MSB) -> {valid, EDCBA}. K28 is handled separately.
    function automatic logic [5:0] dec6(input logic [5:0] c);
        logic [5:0] r;
        r = 6'd0;
        case (c)
            6'b100111, 6'b011000: r = {1'b1, 5'd0};
            6'b011101, 6'b100010: r = {1'b1, 5'd1};
            6'b101101, 6'b010010: r = {1'b1, 5'd2};
            6'b110001:            r = {1'b1, 5'd3};
            6'b110101, 6'b001010: r = {1'b1, 5'd4};
            6'b101001:            r = {1'b1, 5'd5};
            6'b011001:            r = {1'b1, 5'd6};
            6'b111000, 6'b000111: r = {1'b1, 5'd7};
            6'b111001, 6'b000110: r = {1'b1, 5'd8};
            6'b100101:            r = {1'b1, 5'd9};
            6'b010101:            r = {1'b1, 5'd10};
            6'b110100:            r = {1'b1, 5'd11};
            6'b001101:            r = {1'b1, 5'd12};
            6'b101100:            r = {1'b1, 5'd13};
            6'b011100:            r = {1'b1, 5'd14};
            6'b010111, 6'b101000: r = {1'b1, 5'd15};
            6'b011011, 6'b100100: r = {1'b1, 5'd16};
            6'b100011:            r = {1'b1, 5'd17};
            6'b010011:            r = {1'b1, 5'd18};
            6'b110010:            r = {1'b1, 5'd19};
            6'b001011:            r = {1'b1, 5'd20};
            6'b101010:            r = {1'b1, 5'd21};
            6'b011010:            r = {1'b1, 5'd22};
            6'b111010, 6'b000101: r = {1'b1, 5'd23};
            6'b110011, 6'b001100: r = {1'b1, 5'd24};
            6'b100110:            r = {1'b1, 5'd25};
            6'b010110:            r = {1'b1, 5'd26};
            6'b110110, 6'b001001: r = {1'b1, 5'd27};
            6'b001110:            r = {1'b1, 5'd28};
            6'b101110, 6'b010001: r = {1'b1, 5'd29};
            6'b011110, 6'b100001: r = {1'b1, 5'd30};
            6'b101011, 6'b010100: r = {1'b1, 5'd31};
            default:              r = 6'd0;
        endcase
        return r;
    endfunction

    // 4b code in fghj order (f = MSB) -> {valid, primary_7, HGF}.
    function automatic logic [4:0] dec4(input logic [3:0] c);
        logic [4:0] r;
        r = 5'd0;
        case (c)
            4'b1011, 4'b0100: r = {2'b10, 3'd0};
            4'b1001:          r = {2'b10, 3'd1};
            4'b0101:          r = {2'b10, 3'd2};
            4'b1100, 4'b0011: r = {2'b10, 3'd3};
            4'b1101, 4'b0010: r = {2'b10, 3'd4};
            4'b1010:          r = {2'b10, 3'd5};
            4'b0110:          r = {2'b10, 3'd6};
            4'b1110, 4'b0001: r = {2'b11, 3'd7};
            4'b0111, 4'b1000: r = {2'b10, 3'd7};
            default:          r = 5'd0;
        endcase
        return r;
    endfunction

    logic [NUM_SYMBOLS-1:0]   pos6, neg6, req6m, req6p, pos4, neg4, req4m, req4p;
    logic [NUM_SYMBOLS-1:0]   derr, kflag, disp_err_c;
    logic [8*NUM_SYMBOLS-1:0] bytes_w;
    logic                     rd_c;

    logic                     vout_q, vout_d;
    logic [8*NUM_SYMBOLS-1:0] bytes_q, bytes_d;
    logic [NUM_SYMBOLS-1:0]   k_q, k_d, derr_q, derr_d, disp_q, disp_d;
    logic                     rd_q, rd_d;
    logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Per-symbol decode: everything that does not depend on running disparity.
    for (genvar gi = 0; gi < NUM_SYMBOLS; gi++) begin : g_sym
        logic [9:0] sym;
        logic [5:0] c6;
        logic [3:0] c4, c4_dec;
        logic [5:0] d6;
        logic [4:0] d4;
        logic       is_k28, is_kx7, a7_raw, a7_ok;

        assign sym    = RxParallel_10[10*gi +: 10];
        assign c6     = {sym[0], sym[1], sym[2], sym[3], sym[4], sym[5]};
        assign c4     = {sym[6], sym[7], sym[8], sym[9]};
        assign is_k28 = (c6 == 6'b001111) || (c6 == 6'b110000);
        // After the RD+ form of K28 the 4b half uses the inverted K column;
        // inverting it lets the data table decode every K28.y.
        assign c4_dec = (c6 == 6'b110000) ? ~c4 : c4;
        assign d6     = dec6(c6);
        assign d4     = dec4(c4_dec);
        assign a7_raw = (c4 == 4'b0111) || (c4 == 4'b1000);

        // Which 6b codes may be followed by an alternate-7 4b code, and K23/27/29/30.
        always_comb begin
            is_kx7 = 1'b0;
            a7_ok  = 1'b0;
            case (c6)
                6'b100011, 6'b010011, 6'b001011, 6'b110000: a7_ok = (c4 == 4'b0111);
                6'b110100, 6'b101100, 6'b011100, 6'b001111: a7_ok = (c4 == 4'b1000);
                6'b000101, 6'b001001, 6'b010001, 6'b100001: begin
                    is_kx7 = 1'b1;
                    a7_ok  = (c4 == 4'b0111);
                end
                6'b111010, 6'b110110, 6'b101110, 6'b011110: begin
                    is_kx7 = 1'b1;
                    a7_ok  = (c4 == 4'b1000);
                end
                default: ;
            endcase
        end

        assign derr[gi]  = ~(d6[5] | is_k28) | ~d4[4] | (a7_raw & ~a7_ok) | (is_k28 & d4[3]);
        assign kflag[gi] = is_k28 | (is_kx7 & a7_raw);
        assign bytes_w[8*gi +: 8] = {d4[2:0], (is_k28 ? 5'd28 : d6[4:0])};
        assign pos6[gi]  = ($countones(c6) > 3);
        assign neg6[gi]  = ($countones(c6) < 3);
        assign pos4[gi]  = ($countones(c4) > 2);
        assign neg4[gi]  = ($countones(c4) < 2);
        assign req6m[gi] = (c6 == 6'b111000);
        assign req6p[gi] = (c6 == 6'b000111);
        assign req4m[gi] = (c4 == 4'b1100);
        assign req4p[gi] = (c4 == 4'b0011);
    end

    // Disparity chain: each sub-block is checked against the RD left by the previous one.
    always_comb begin
        logic e6, e4;
        e6         = 1'b0;
        e4         = 1'b0;
        rd_c       = rd_q;
        disp_err_c = '0;
        for (int k = 0; k < NUM_SYMBOLS; k++) begin
            e6 = (pos6[k] & rd_c) | (neg6[k] & ~rd_c) | (req6m[k] & rd_c) | (req6p[k] & ~rd_c);
            if (pos6[k])      rd_c = 1'b1;
            else if (neg6[k]) rd_c = 1'b0;
            e4 = (pos4[k] & rd_c) | (neg4[k] & ~rd_c) | (req4m[k] & rd_c) | (req4p[k] & ~rd_c);
            if (pos4[k])      rd_c = 1'b1;
            else if (neg4[k]) rd_c = 1'b0;
            disp_err_c[k] = (e6 | e4) & ~derr[k];
        end
    end

    // Next-state for the output registers, running disparity and error counter.
    always_comb begin
        vout_d  = RxValid;
        bytes_d = '0;
        k_d     = '0;
        derr_d  = '0;
        disp_d  = '0;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (RxValid) begin
            rd_d   = rd_c;
            derr_d = derr;
            disp_d = disp_err_c;
            for (int k = 0; k < NUM_SYMBOLS; k++) begin
                if (!derr[k]) begin
                    bytes_d[8*k +: 8] = bytes_w[8*k +: 8];
                    k_d[k]            = kflag[k];
                end
                if ((derr[k] || disp_err_c[k]) && (cnt_d != '1)) begin
                    cnt_d = cnt_d + ERR_CNT_WIDTH'(1);
                end
            end
        end
        if (ErrCntClear) cnt_d = '0;
    end

    // Output and state registers.
    always_ff @(posedge BitCLK_10 or posedge Reset) begin
        if (Reset) begin
            vout_q  <= 1'b0;
            bytes_q <= '0;
            k_q     <= '0;
            derr_q  <= '0;
            disp_q  <= '0;
            rd_q    <= RD_INIT;
            cnt_q   <= '0;
        end else begin
            vout_q  <= vout_d;
            bytes_q <= bytes_d;
            k_q     <= k_d;
            derr_q  <= derr_d;
            disp_q  <= disp_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign RxValidOut       = vout_q;
    assign RxParallel_8     = bytes_q;
    assign RxDataK          = k_q;
    assign decode_error     = derr_q;
    assign disparity_error  = disp_q;
    assign RunningDisparity = rd_q;
    assign ErrCount         = cnt_q;

endmodule

// File: tb/tb_decoder_8b10b_multilane.sv
// Bench for the multi-lane 8b/10b decoder: a default instance driven from a
// vector table through a scoreboard queue, and a second instance
// (ERR_CNT_WIDTH=2, RD_INIT=1) for saturation, RD_INIT and async reset cases.
module tb_decoder_8b10b_multilane;

    typedef struct {
        logic        v;
        logic        clr;
        logic [19:0] d10;
        logic        ev;
        logic [15:0] eb;
        logic [1:0]  ek;
        logic [1:0]  edec;
        logic [1:0]  edisp;
        logic        erd;
        logic [15:0] ecnt;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters.
    logic        rst_a, valid_a, clr_a;
    logic [19:0] d10_a;
    logic        vout_a, rd_a;
    logic [15:0] bytes_a, cnt_a;
    logic [1:0]  k_a, dec_a, disp_a;

    // Instance B: 2-bit counter, RD_INIT = RD+.
    logic        rst_b, valid_b, clr_b;
    logic [19:0] d10_b;
    logic        vout_b, rd_b;
    logic [15:0] bytes_b;
    logic [1:0]  cnt_b;
    logic [1:0]  k_b, dec_b, disp_b;

    decoder_8b10b_multilane dut_a (
        .BitCLK_10        (clk),
        .Reset            (rst_a),
        .RxValid          (valid_a),
        .RxParallel_10    (d10_a),
        .ErrCntClear      (clr_a),
        .RxValidOut       (vout_a),
        .RxParallel_8     (bytes_a),
        .RxDataK          (k_a),
        .decode_error     (dec_a),
        .disparity_error  (disp_a),
        .RunningDisparity (rd_a),
        .ErrCount         (cnt_a)
    );

    decoder_8b10b_multilane #(
        .NUM_SYMBOLS   (2),
        .ERR_CNT_WIDTH (2),
        .RD_INIT       (1'b1)
    ) dut_b (
        .BitCLK_10        (clk),
        .Reset            (rst_b),
        .RxValid          (valid_b),
        .RxParallel_10    (d10_b),
        .ErrCntClear      (clr_b),
        .RxValidOut       (vout_b),
        .RxParallel_8     (bytes_b),
        .RxDataK          (k_b),
        .decode_error     (dec_b),
        .disparity_error  (disp_b),
        .RunningDisparity (rd_b),
        .ErrCount         (cnt_b)
    );

    int   errors = 0;
    int   checks = 0;
    vec_t sb_a[$];
    vec_t sb_b[$];
    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic is_b);
        vec_t e;
        if ((is_b ? sb_b.size() : sb_a.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no expected entry queued for DUT output", tag);
            return;
        end
        if (is_b) e = sb_b.pop_front();
        else      e = sb_a.pop_front();
        if (!is_b) begin
            $display("%s A in v=%0b clr=%0b d=%05h | out v=%0b b=%04h k=%b dec=%b disp=%b rd=%0b cnt=%0d",
                     tag, e.v, e.clr, e.d10, vout_a, bytes_a, k_a, dec_a, disp_a, rd_a, cnt_a);
            chk({tag, ".valid"}, 32'(vout_a),  32'(e.ev));
            chk({tag, ".bytes"}, 32'(bytes_a), 32'(e.eb));
            chk({tag, ".k"},     32'(k_a),     32'(e.ek));
            chk({tag, ".dec"},   32'(dec_a),   32'(e.edec));
            chk({tag, ".disp"},  32'(disp_a),  32'(e.edisp));
            chk({tag, ".rd"},    32'(rd_a),    32'(e.erd));
            chk({tag, ".cnt"},   32'(cnt_a),   32'(e.ecnt));
        end else begin
            $display("%s B in v=%0b clr=%0b d=%05h | out v=%0b b=%04h k=%b dec=%b disp=%b rd=%0b cnt=%0d",
                     tag, e.v, e.clr, e.d10, vout_b, bytes_b, k_b, dec_b, disp_b, rd_b, cnt_b);
            chk({tag, ".valid"}, 32'(vout_b),  32'(e.ev));
            chk({tag, ".bytes"}, 32'(bytes_b), 32'(e.eb));
            chk({tag, ".k"},     32'(k_b),     32'(e.ek));
            chk({tag, ".dec"},   32'(dec_b),   32'(e.edec));
            chk({tag, ".disp"},  32'(disp_b),  32'(e.edisp));
            chk({tag, ".rd"},    32'(rd_b),    32'(e.erd));
            chk({tag, ".cnt"},   32'(cnt_b),   32'(e.ecnt));
        end
    endtask

    // Drive one cycle of input, queue its expectation, check one cycle later.
    task automatic step(input vec_t v, input string tag, input logic is_b);
        @(negedge clk);
        if (is_b) begin
            valid_b = v.v; clr_b = v.clr; d10_b = v.d10;
            sb_b.push_back(v);
        end else begin
            valid_a = v.v; clr_a = v.clr; d10_a = v.d10;
            sb_a.push_back(v);
        end
        @(posedge clk);
        #1;
        pop_check(tag, is_b);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t s;
        // {valid, clr, {slot1, slot0}, exp valid, bytes, K, dec_err, disp_err, RD, count}
        vecs[0]  = '{1'b1, 1'b0, {10'h283, 10'h17C}, 1'b1, 16'hBCBC, 2'b11, 2'b00, 2'b00, 1'b0, 16'd0};
        vecs[1]  = '{1'b1, 1'b0, {10'h0B9, 10'h0B9}, 1'b1, 16'h0000, 2'b00, 2'b00, 2'b00, 1'b0, 16'd0};
        vecs[2]  = '{1'b1, 1'b0, {10'h155, 10'h155}, 1'b1, 16'hB5B5, 2'b00, 2'b00, 2'b00, 1'b0, 16'd0};
        vecs[3]  = '{1'b1, 1'b0, {10'h17C, 10'h17C}, 1'b1, 16'hBCBC, 2'b11, 2'b00, 2'b10, 1'b1, 16'd1};
        vecs[4]  = '{1'b1, 1'b0, {10'h17C, 10'h000}, 1'b1, 16'hBC00, 2'b10, 2'b01, 2'b00, 1'b1, 16'd2};
        vecs[5]  = '{1'b0, 1'b0, {10'h000, 10'h000}, 1'b0, 16'h0000, 2'b00, 2'b00, 2'b00, 1'b1, 16'd2};
        vecs[6]  = '{1'b1, 1'b0, {10'h155, 10'h283}, 1'b1, 16'hB5BC, 2'b01, 2'b00, 2'b00, 1'b0, 16'd2};
        // D17.A7 is legal; D9 followed by an alternate 7 is not.
        vecs[7]  = '{1'b1, 1'b0, {10'h069, 10'h3B1}, 1'b1, 16'h00F1, 2'b00, 2'b10, 2'b00, 1'b0, 16'd3};
        // K23.7 is legal; K28 with a primary-7 partner is not.
        vecs[8]  = '{1'b1, 1'b0, {10'h23C, 10'h057}, 1'b1, 16'h00F7, 2'b01, 2'b10, 2'b00, 1'b0, 16'd4};
        // Clear wins over errors in the same cycle.
        vecs[9]  = '{1'b1, 1'b1, {10'h17C, 10'h17C}, 1'b1, 16'hBCBC, 2'b11, 2'b00, 2'b10, 1'b1, 16'd0};
        // Balanced 6b 000111 form is only legal at RD+.
        vecs[10] = '{1'b1, 1'b0, {10'h378, 10'h0B8}, 1'b1, 16'h0707, 2'b00, 2'b00, 2'b10, 1'b1, 16'd1};
        // Balanced 4b 1100 form is only legal at RD-.
        vecs[11] = '{1'b1, 1'b0, {10'h315, 10'h0D5}, 1'b1, 16'h7575, 2'b00, 2'b00, 2'b01, 1'b1, 16'd2};
        // K28.7 and K28.1 in their RD+ forms.
        vecs[12] = '{1'b1, 1'b0, {10'h183, 10'h383}, 1'b1, 16'h3CFC, 2'b11, 2'b00, 2'b00, 1'b0, 16'd2};

        rst_a = 1'b1; valid_a = 1'b0; clr_a = 1'b0; d10_a = '0;
        rst_b = 1'b1; valid_b = 1'b0; clr_b = 1'b0; d10_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("a.reset.valid", 32'(vout_a),  32'd0);
        chk("a.reset.bytes", 32'(bytes_a), 32'd0);
        chk("a.reset.flags", 32'({k_a, dec_a, disp_a}), 32'd0);
        chk("a.reset.rd",    32'(rd_a),    32'd0);
        chk("a.reset.cnt",   32'(cnt_a),   32'd0);
        chk("b.reset.rd",    32'(rd_b),    32'd1);
        chk("b.reset.cnt",   32'(cnt_b),   32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        for (int i = 0; i < 13; i++) step(vecs[i], $sformatf("vec%0d", i), 1'b0);

        // Instance B: first symbol checked against RD_INIT = RD+.
        s = '{1'b1, 1'b0, {10'h155, 10'h283}, 1'b1, 16'hB5BC, 2'b01, 2'b00, 2'b00, 1'b0, 16'd0};
        step(s, "b.rdinit", 1'b1);
        // Two errors per cycle saturate the 2-bit counter at 3.
        for (int i = 0; i < 4; i++) begin
            s = '{1'b1, 1'b0, 20'h00000, 1'b1, 16'h0000, 2'b00, 2'b11, 2'b00, 1'b0,
                  (i == 0) ? 16'd2 : 16'd3};
            step(s, $sformatf("b.sat%0d", i), 1'b1);
        end
        s = '{1'b1, 1'b1, 20'h00000, 1'b1, 16'h0000, 2'b00, 2'b11, 2'b00, 1'b0, 16'd0};
        step(s, "b.clear", 1'b1);
        s = '{1'b1, 1'b0, 20'h00000, 1'b1, 16'h0000, 2'b00, 2'b11, 2'b00, 1'b0, 16'd2};
        step(s, "b.preerr", 1'b1);

        // Asynchronous reset in the middle of a cycle clears outputs at once.
        #3;
        rst_b = 1'b1;
        #1;
        $display("b.arst out v=%0b b=%04h dec=%b rd=%0b cnt=%0d", vout_b, bytes_b, dec_b, rd_b, cnt_b);
        chk("b.arst.valid", 32'(vout_b),  32'd0);
        chk("b.arst.bytes", 32'(bytes_b), 32'd0);
        chk("b.arst.dec",   32'(dec_b),   32'd0);
        chk("b.arst.rd",    32'(rd_b),    32'd1);
        chk("b.arst.cnt",   32'(cnt_b),   32'd0);
        @(negedge clk);
        valid_b = 1'b0;
        rst_b   = 1'b0;
        // RD+ again after reset, so K28.5 in its RD- form is a disparity error.
        s = '{1'b1, 1'b0, {10'h155, 10'h17C}, 1'b1, 16'hB5BC, 2'b01, 2'b00, 2'b01, 1'b1, 16'd1};
        step(s, "b.postrst", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
